// File: rtl/shift_pkg.sv
// Shared types and constants for the execute-stage shift arbiter.
package shift_pkg;

    localparam int SH_W = 32;

    typedef enum logic [2:0] {
        LSL = 3'd0,
        LSR = 3'd1,
        ASR = 3'd2,
        ROR = 3'd3,
        RRX = 3'd4
    } shift_op_t;

    typedef struct packed {
        logic            id;
        logic [SH_W-1:0] data;
        logic            cout;
        logic            err;
    } shift_rsp_t;

endpackage

// File: rtl/rot_right.sv
// Combinational 32-bit rotate-right by a 5-bit amount.
module rot_right (
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    output logic [31:0] result
);

    logic [63:0] dbl_s;

    // Rotating the doubled word right leaves the rotated value in the low half.
    always_comb begin
        dbl_s  = {data, data} >> amt;
        result = dbl_s[31:0];
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel rotator between the operand-2 path
// (requester 0) and the load/store offset path (requester 1). ARM shift
// semantics are built from the rotation with masks, sign fill and carry select.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [2:0]    req_op0,
    input  logic [2:0]    req_op1,
    input  logic [AW-1:0] req_amt0,
    input  logic [AW-1:0] req_amt1,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    input  logic          req_cin0,
    input  logic          req_cin1,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_cout,
    output logic          rsp_err
);

    logic          last_grant_r;
    logic          rsp_valid_r;
    shift_rsp_t    rsp_r;

    logic [1:0]    grant_s;
    logic          can_accept_s;
    logic          accept_s;
    logic          sel_s;

    logic [2:0]    op_s;
    logic [AW-1:0] amt_s;
    logic [DW-1:0] d_s;
    logic          c_s;

    logic [4:0]    lo_s;
    logic [4:0]    rot_amt_s;
    logic [DW-1:0] rot_s;
    logic [DW-1:0] lmask_s;
    logic [DW-1:0] rmask_s;
    logic [DW-1:0] fill_s;
    logic          amt_zero_s;
    logic          amt_lt32_s;
    logic          amt_eq32_s;
    shift_rsp_t    next_s;

    // Grant: single requester wins outright; on conflict the one not served last wins.
    always_comb begin
        grant_s = 2'b00;
        if (req_valid == 2'b11) begin
            if (last_grant_r) begin
                grant_s = 2'b01;
            end else begin
                grant_s = 2'b10;
            end
        end else begin
            grant_s = req_valid;
        end
    end

    // Accept only when the response slot is free or draining this cycle, never in reset.
    always_comb begin
        can_accept_s = !rsp_valid_r || rsp_ready;
        if (rst || !can_accept_s) begin
            req_ready = 2'b00;
        end else begin
            req_ready = grant_s;
        end
        accept_s = |(req_valid & req_ready);
        sel_s    = grant_s[1];
    end

    // Operand mux in front of the shared rotator.
    always_comb begin
        if (sel_s) begin
            op_s  = req_op1;
            amt_s = req_amt1;
            d_s   = req_data1;
            c_s   = req_cin1;
        end else begin
            op_s  = req_op0;
            amt_s = req_amt0;
            d_s   = req_data0;
            c_s   = req_cin0;
        end
    end

    // Left shifts rotate right by (32-n) mod 32; everything else rotates by n mod 32.
    always_comb begin
        lo_s       = amt_s[4:0];
        amt_zero_s = (amt_s == {AW{1'b0}});
        amt_lt32_s = (amt_s < AW'(32));
        amt_eq32_s = (amt_s == AW'(32));
        if (op_s == 3'(LSL)) begin
            rot_amt_s = 5'd0 - lo_s;
        end else begin
            rot_amt_s = lo_s;
        end
        lmask_s = {DW{1'b1}} << lo_s;
        rmask_s = {DW{1'b1}} >> lo_s;
        fill_s  = {DW{d_s[DW-1]}};
    end

    rot_right u_rot (
        .data   (d_s),
        .amt    (rot_amt_s),
        .result (rot_s)
    );

    // Result and carry-out selection for each opcode and amount range.
    always_comb begin
        next_s = '{id: sel_s, data: {SH_W{1'b0}}, cout: c_s, err: 1'b0};
        case (op_s)
            LSL: begin
                if (amt_zero_s) begin
                    next_s.data = d_s;
                    next_s.cout = c_s;
                end else if (amt_lt32_s) begin
                    next_s.data = rot_s & lmask_s;
                    next_s.cout = d_s[rot_amt_s];
                end else if (amt_eq32_s) begin
                    next_s.data = {SH_W{1'b0}};
                    next_s.cout = d_s[0];
                end else begin
                    next_s.data = {SH_W{1'b0}};
                    next_s.cout = 1'b0;
                end
            end
            LSR: begin
                if (amt_zero_s) begin
                    next_s.data = d_s;
                    next_s.cout = c_s;
                end else if (amt_lt32_s) begin
                    next_s.data = rot_s & rmask_s;
                    next_s.cout = d_s[lo_s - 5'd1];
                end else if (amt_eq32_s) begin
                    next_s.data = {SH_W{1'b0}};
                    next_s.cout = d_s[DW-1];
                end else begin
                    next_s.data = {SH_W{1'b0}};
                    next_s.cout = 1'b0;
                end
            end
            ASR: begin
                if (amt_zero_s) begin
                    next_s.data = d_s;
                    next_s.cout = c_s;
                end else if (amt_lt32_s) begin
                    next_s.data = (rot_s & rmask_s) | (fill_s & ~rmask_s);
                    next_s.cout = d_s[lo_s - 5'd1];
                end else begin
                    next_s.data = fill_s;
                    next_s.cout = d_s[DW-1];
                end
            end
            ROR: begin
                if (amt_zero_s) begin
                    next_s.data = d_s;
                    next_s.cout = c_s;
                end else begin
                    // A multiple of 32 leaves rot_s == d_s, so bit 31 is d[31] as required.
                    next_s.data = rot_s;
                    next_s.cout = rot_s[DW-1];
                end
            end
            RRX: begin
                next_s.data = {c_s, d_s[DW-1:1]};
                next_s.cout = d_s[0];
            end
            default: begin
                next_s.data = {SH_W{1'b0}};
                next_s.cout = c_s;
                next_s.err  = 1'b1;
            end
        endcase
    end

    // Response register and round-robin pointer; both move only on an accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r  <= 1'b0;
            rsp_r        <= '{id: 1'b0, data: {SH_W{1'b0}}, cout: 1'b0, err: 1'b0};
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_r        <= next_s;
            last_grant_r <= sel_s;
        end else if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_r.id;
    assign rsp_data  = rsp_r.data;
    assign rsp_cout  = rsp_r.cout;
    assign rsp_err   = rsp_r.err;

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester arbiter and sequencer for the shared 32-bit barrel rotator in the execute stage. It accepts ARM-style shift requests (LSL/LSR/ASR/ROR/RRX, register-specified amount 0–255) from the operand-2 path (requester 0) and the load/store offset path (requester 1). It grants them round-robin, computes result and shifter carry-out through one `rot_right` instance, and presents a registered response on a valid/ready channel.

## Interface
Parameters:
- `DW`, default 32: data width. Fixed at 32; the `rot_right` instance is 32-bit only.
- `AW`, default 8: shift-amount width (Rs[7:0]).

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid[1:0]` in 2: per-requester request valid.
- `req_ready[1:0]` out 2: per-requester accept.
- `req_op0`, `req_op1` in 3 each: shift opcode (`shift_op_t`).
- `req_amt0`, `req_amt1` in `AW` each: shift amount.
- `req_data0`, `req_data1` in `DW` each: operand.
- `req_cin0`, `req_cin1` in 1 each: CPSR C in.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out 1: requester that issued the response.
- `rsp_data` out `DW`: shifted result.
- `rsp_cout` out 1: shifter carry-out.
- `rsp_err` out 1: illegal opcode flag.

## Operation
- Handshakes:
  - A request transfers when `req_valid[i] && req_ready[i]`.
  - A response transfers when `rsp_valid && rsp_ready`.
  - A valid request holds all its fields stable until accepted.
- Arbitration:
  - `last_grant` is a 1-bit register, reset to 1, so requester 0 wins first.
  - When only one requester is valid, it is granted.
  - When both are valid, the requester not equal to `last_grant` is granted.
  - `last_grant` updates only on an accepted transfer.
- `req_ready[i] = grant[i] && (!rsp_valid || rsp_ready)`. At most one `req_ready` bit is high per cycle.
- `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Datapath: the muxed operand goes to `rot_right`. The rotate amount is `amt[4:0]` for LSR/ASR/ROR and `(32-amt[4:0])[4:0]` for LSL, followed by masking and sign fill.
- Shift semantics (n = amount, d = data, c = cin):
  - n = 0, any op except RRX: data = d, cout = c.
  - LSL, 1–31: data = d<<n, cout = d[32-n].
  - LSL, 32: data = 0, cout = d[0].
  - LSL, >32: data = 0, cout = 0.
  - LSR, 1–31: data = d>>n, cout = d[n-1].
  - LSR, 32: data = 0, cout = d[31].
  - LSR, >32: data = 0, cout = 0.
  - ASR, 1–31: data = arithmetic shift right by n, cout = d[n-1].
  - ASR, ≥32: data = {32{d[31]}}, cout = d[31].
  - ROR, n[4:0] ≠ 0: data = rotate right by n[4:0], cout = result[31].
  - ROR, n ≠ 0 and n[4:0] = 0: data = d, cout = d[31].
  - RRX: ignores amount; data = {c, d[31:1]}, cout = d[0].
- Opcodes 5–7 are illegal: data = 0, cout = c, `rsp_err` = 1. An illegal request is still accepted and still updates `last_grant`.
- Response register: it loads on acceptance. It holds while `rsp_valid && !rsp_ready`. It clears `rsp_valid` when consumed with no new accept in the same cycle.

## Timing
- Latency: accept in cycle N gives `rsp_valid` = 1 in cycle N+1 with its result.
- Throughput: 1 per cycle while `rsp_ready` is held high.
- Back-pressure: while `rsp_valid && !rsp_ready`, both `req_ready` bits are 0 and the response fields are frozen.
- Simultaneous consume and accept: `rsp_valid` stays 1 and the fields update to the new request. No bubble is inserted.
- Reset: `rst` high at an edge forces the following, regardless of the in-flight state, and discards any pending response:
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_cout` = 0, `rsp_err` = 0, `last_grant` = 1.
  - `req_ready` is 0 during every cycle in which `rst` is sampled high.

## Structure
- Package `shift_pkg`:
  - `shift_op_t` enum: LSL=0, LSR=1, ASR=2, ROR=3, RRX=4.
  - `SH_W` = 32.
  - `shift_rsp_t` struct: id, data, cout, err.
- Sub-module: one instance of the existing combinational `rot_right` (32-bit input, 5-bit amount).
- Masks, sign fill, carry select and the arbiter stay inline in `shift_arbiter`.

## Test plan
- Reset, then req0 LSL n=4, d=0x0000_000F, c=0 → next cycle `rsp_valid`, id=0, data=0x0000_00F0, cout=0.
- Both valid every cycle with `rsp_ready`=1:
  - req0 ROR n=8, d=0x1234_5678.
  - req1 LSR n=32, d=0x8000_0001.
  - Expected: grants alternate 0,1,0,1. Responses are 0x7812_3456/cout 0 and 0x0000_0000/cout 1.
- `rsp_ready`=0 for 3 cycles with req1 pending → `req_ready`=00 and response fields stable. On release, req1 is accepted the same cycle the old response is consumed.
- Corner amounts on d=0x8000_0001, c=1:
  - LSL n=33 → 0 / cout 0.
  - ASR n=200 → 0xFFFF_FFFF / cout 1.
  - ROR n=64 → d unchanged / cout 1.
  - LSR n=0 → d unchanged / cout 1.
- RRX on d=0x0000_0003, c=1 → 0x8000_0001 / cout 1. Opcode 6 → data 0, cout=c, `rsp_err`=1.
- Assert `rst` while `rsp_valid`=1 and `rsp_ready`=0 → next cycle all outputs are 0. The first post-reset conflict is granted to req0.
